// File: rtl/ibex_efpga_cx_if.sv
// ibex_efpga_cx_if
// Bundles the EX-stage request/response and the eFPGA fabric signals of the
// custom-instruction unit.
//   EX side    : en_i, operator_i, operand_a_i, operand_b_i, delay_i, kill_i,
//                result_o, ready_o, busy_o, err_o
//   fabric side: efpga_operand_a_o, efpga_operand_b_o, efpga_start_o,
//                efpga_result_i (channel k = [k*DATA_W +: DATA_W]), efpga_done_i
// slave modport = the CX unit, master modport = its environment.
interface ibex_efpga_cx_if #(
  parameter int NUM_CH  = 4,
  parameter int DATA_W  = 32,
  parameter int DELAY_W = 4
);
  localparam int CH_W = $clog2(NUM_CH);

  logic                     en_i;
  logic [CH_W-1:0]          operator_i;
  logic [DATA_W-1:0]        operand_a_i;
  logic [DATA_W-1:0]        operand_b_i;
  logic [DELAY_W-1:0]       delay_i;
  logic                     kill_i;
  logic [DATA_W-1:0]        efpga_operand_a_o;
  logic [DATA_W-1:0]        efpga_operand_b_o;
  logic                     efpga_start_o;
  logic [NUM_CH*DATA_W-1:0] efpga_result_i;
  logic [NUM_CH-1:0]        efpga_done_i;
  logic [DATA_W-1:0]        result_o;
  logic                     ready_o;
  logic                     busy_o;
  logic                     err_o;

  modport slave (
    input  en_i, operator_i, operand_a_i, operand_b_i, delay_i, kill_i,
           efpga_result_i, efpga_done_i,
    output efpga_operand_a_o, efpga_operand_b_o, efpga_start_o,
           result_o, ready_o, busy_o, err_o
  );

  modport master (
    output en_i, operator_i, operand_a_i, operand_b_i, delay_i, kill_i,
           efpga_result_i, efpga_done_i,
    input  efpga_operand_a_o, efpga_operand_b_o, efpga_start_o,
           result_o, ready_o, busy_o, err_o
  );
endinterface

// File: rtl/ibex_efpga_cx_unit.sv
// ibex_efpga_cx_unit
// Multi-cycle custom-instruction execution unit toward the eFPGA fabric.
// Registers operands, pulses start, waits either a fixed number of cycles
// (delay_i > 0) or for the selected channel's done bit (delay_i == 0), then
// presents the captured result with ready_o for one cycle.
// Ports: clk, rst (async, active-high), cx (ibex_efpga_cx_if.slave, see the
// interface file for the signal list).
// Optional: define EFPGA_CX_TIMEOUT_EN to abort handshake-mode operations
// after TIMEOUT BUSY cycles (result 0, err_o set).
//
// state | meaning
// IDLE  | waiting for en_i; accepts and latches the operation
// BUSY  | fabric computing; fixed countdown or waiting on done
// DONE  | ready_o high for one cycle with the captured result
module ibex_efpga_cx_unit #(
  parameter int NUM_CH  = 4,
  parameter int DATA_W  = 32,
  parameter int DELAY_W = 4,
  parameter int TIMEOUT = 255
) (
  input logic            clk,
  input logic            rst,
  ibex_efpga_cx_if.slave cx
);
  localparam int CH_W = $clog2(NUM_CH);

  if (NUM_CH < 2 || (NUM_CH & (NUM_CH - 1)) != 0) begin : g_bad_num_ch
    $error("NUM_CH must be a power of 2 and at least 2");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  op_a_q, op_a_d;
  logic [DATA_W-1:0]  op_b_q, op_b_d;
  logic [DATA_W-1:0]  result_q, result_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic [DELAY_W-1:0] cnt_q, cnt_d;
  logic               mode_q, mode_d;   // 1 = handshake mode
  logic               start_q, start_d; // high in the first BUSY cycle
  logic               err_q, err_d;

  logic [DATA_W-1:0]  res_ch [NUM_CH];
  for (genvar k = 0; k < NUM_CH; k++) begin : g_res_ch
    assign res_ch[k] = cx.efpga_result_i[k*DATA_W +: DATA_W];
  end

`ifdef EFPGA_CX_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`endif

  always_comb begin
    state_d  = state_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    result_d = result_q;
    ch_d     = ch_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    start_d  = 1'b0;
    err_d    = err_q;
`ifdef EFPGA_CX_TIMEOUT_EN
    to_cnt_d = to_cnt_q;
`endif
    if (cx.kill_i) begin
      // Abort wins over accept, done and counter expiry; nothing is captured.
      state_d = IDLE;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cx.en_i) begin
            state_d = BUSY;
            op_a_d  = cx.operand_a_i;
            op_b_d  = cx.operand_b_i;
            ch_d    = cx.operator_i;
            cnt_d   = cx.delay_i;
            mode_d  = (cx.delay_i == '0);
            start_d = 1'b1;
            err_d   = 1'b0;
`ifdef EFPGA_CX_TIMEOUT_EN
            to_cnt_d = '0;
`endif
          end
        end
        BUSY: begin
          if (!mode_q) begin
            if (cnt_q == DELAY_W'(1)) begin
              result_d = res_ch[ch_q];
              state_d  = DONE;
            end else begin
              cnt_d = cnt_q - 1'b1;
            end
          end else if (cx.efpga_done_i[ch_q]) begin
            result_d = res_ch[ch_q];
            state_d  = DONE;
          end
`ifdef EFPGA_CX_TIMEOUT_EN
          // to_cnt_q counts completed BUSY cycles, so TIMEOUT-1 marks the last one.
          else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
            result_d = '0;
            err_d    = 1'b1;
            state_d  = DONE;
          end else begin
            to_cnt_d = to_cnt_q + 1'b1;
          end
`endif
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      op_a_q   <= '0;
      op_b_q   <= '0;
      result_q <= '0;
      ch_q     <= '0;
      cnt_q    <= '0;
      mode_q   <= 1'b0;
      start_q  <= 1'b0;
      err_q    <= 1'b0;
`ifdef EFPGA_CX_TIMEOUT_EN
      to_cnt_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      result_q <= result_d;
      ch_q     <= ch_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      start_q  <= start_d;
      err_q    <= err_d;
`ifdef EFPGA_CX_TIMEOUT_EN
      to_cnt_q <= to_cnt_d;
`endif
    end
  end

  assign cx.efpga_operand_a_o = op_a_q;
  assign cx.efpga_operand_b_o = op_b_q;
  assign cx.efpga_start_o     = start_q && !cx.kill_i;
  assign cx.result_o          = result_q;
  assign cx.ready_o           = (state_q == DONE) && !cx.kill_i;
  assign cx.busy_o            = (state_q == BUSY);
`ifdef EFPGA_CX_TIMEOUT_EN
  assign cx.err_o             = err_q;
`else
  assign cx.err_o             = 1'b0;
`endif

endmodule

// File: tb/tb_ibex_efpga_cx_unit.sv
module tb_ibex_efpga_cx_unit;
  localparam int NUM_CH  = 4;
  localparam int DATA_W  = 32;
  localparam int DELAY_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   err_cnt = 0;
  int   chk_cnt = 0;
  logic [DATA_W-1:0] ch_val [NUM_CH];

  always #5 clk = ~clk;

  ibex_efpga_cx_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DELAY_W(DELAY_W)) cx ();

  ibex_efpga_cx_unit #(
    .NUM_CH (NUM_CH),
    .DATA_W (DATA_W),
    .DELAY_W(DELAY_W),
    .TIMEOUT(10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cx (cx.slave)
  );

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_results();
    for (int k = 0; k < NUM_CH; k++) cx.efpga_result_i[k*DATA_W +: DATA_W] = ch_val[k];
  endtask

  // Caller is in an IDLE cycle (cycle 0); walks the op through DONE and one more cycle.
  task automatic run_fixed(input int d, input int ch, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp_res;
    exp_res = ch_val[ch];
    cx.en_i        = 1'b1;
    cx.operator_i  = 2'(ch);
    cx.delay_i     = 4'(d);
    cx.operand_a_i = a;
    cx.operand_b_i = b;
    check_val($sformatf("fx%0d_c0_ready", d), {63'b0, cx.ready_o}, 64'd0);
    for (int c = 1; c <= d + 1; c++) begin
      tick();
      check_val($sformatf("fx%0d_c%0d_start", d, c), {63'b0, cx.efpga_start_o}, {63'b0, c == 1});
      check_val($sformatf("fx%0d_c%0d_busy", d, c), {63'b0, cx.busy_o}, {63'b0, c <= d});
      check_val($sformatf("fx%0d_c%0d_ready", d, c), {63'b0, cx.ready_o}, {63'b0, c == d + 1});
      check_val($sformatf("fx%0d_c%0d_opa", d, c), 64'(cx.efpga_operand_a_o), 64'(a));
      check_val($sformatf("fx%0d_c%0d_opb", d, c), 64'(cx.efpga_operand_b_o), 64'(b));
      check_val($sformatf("fx%0d_c%0d_err", d, c), {63'b0, cx.err_o}, 64'd0);
    end
    check_val($sformatf("fx%0d_result", d), 64'(cx.result_o), 64'(exp_res));
    cx.en_i = 1'b0;
    tick();
    check_val($sformatf("fx%0d_after_ready", d), {63'b0, cx.ready_o}, 64'd0);
    check_val($sformatf("fx%0d_after_result", d), 64'(cx.result_o), 64'(exp_res));
  endtask

  initial begin
    cx.en_i = 1'b0; cx.operator_i = '0; cx.operand_a_i = '0; cx.operand_b_i = '0;
    cx.delay_i = '0; cx.kill_i = 1'b0; cx.efpga_done_i = '0;
    ch_val[0] = 32'hA0A0A0A0; ch_val[1] = 32'h11111111;
    ch_val[2] = 32'hDEADBEEF; ch_val[3] = 32'h33333333;
    drive_results();

    // Reset state
    tick(); tick();
    check_val("rst_ready", {63'b0, cx.ready_o}, 64'd0);
    check_val("rst_busy", {63'b0, cx.busy_o}, 64'd0);
    check_val("rst_start", {63'b0, cx.efpga_start_o}, 64'd0);
    check_val("rst_result", 64'(cx.result_o), 64'd0);
    check_val("rst_opa", 64'(cx.efpga_operand_a_o), 64'd0);
    check_val("rst_err", {63'b0, cx.err_o}, 64'd0);
    rst = 1'b0;
    tick();

    // Fixed mode, delay 3, channel 2
    run_fixed(3, 2, 32'h0000_00A1, 32'h0000_00B1);

    // Handshake mode, channel 1; done[0] must be ignored
    cx.en_i = 1'b1; cx.operator_i = 2'd1; cx.delay_i = 4'd0;
    cx.operand_a_i = 32'hCAFE0001; cx.operand_b_i = 32'hCAFE0002;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 2) cx.efpga_done_i = 4'b0001;
      if (c == 3) cx.efpga_done_i = 4'b0000;
      if (c == 5) begin
        ch_val[1] = 32'h12345678; drive_results();
        cx.efpga_done_i = 4'b0010;
      end
      check_val($sformatf("hs_c%0d_busy", c), {63'b0, cx.busy_o}, {63'b0, c <= 5});
      check_val($sformatf("hs_c%0d_ready", c), {63'b0, cx.ready_o}, {63'b0, c == 6});
      check_val($sformatf("hs_c%0d_start", c), {63'b0, cx.efpga_start_o}, {63'b0, c == 1});
    end
    check_val("hs_result", 64'(cx.result_o), 64'h12345678);
    cx.en_i = 1'b0; cx.efpga_done_i = '0;
    tick();

    // Kill mid-op: delay 8, kill in cycle 4
    cx.en_i = 1'b1; cx.operator_i = 2'd3; cx.delay_i = 4'd8;
    for (int c = 1; c <= 5; c++) begin
      tick();
      cx.kill_i = (c == 4);
      check_val($sformatf("kill_c%0d_ready", c), {63'b0, cx.ready_o}, 64'd0);
      check_val($sformatf("kill_c%0d_busy", c), {63'b0, cx.busy_o}, {63'b0, c <= 4});
    end
    check_val("kill_result_kept", 64'(cx.result_o), 64'h12345678);
    run_fixed(2, 0, 32'h5555_0001, 32'h5555_0002);

    // Back-to-back delay-1 ops with en_i held; operands change at second accept
    cx.en_i = 1'b1; cx.operator_i = 2'd3; cx.delay_i = 4'd1;
    cx.operand_a_i = 32'h0000_1111; cx.operand_b_i = 32'h0000_2222;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 2) begin cx.operand_a_i = 32'h0000_3333; cx.operand_b_i = 32'h0000_4444; end
      check_val($sformatf("b2b_c%0d_ready", c), {63'b0, cx.ready_o}, {63'b0, c == 2 || c == 5});
      check_val($sformatf("b2b_c%0d_start", c), {63'b0, cx.efpga_start_o}, {63'b0, c == 1 || c == 4});
      check_val($sformatf("b2b_c%0d_opa", c), 64'(cx.efpga_operand_a_o),
                (c >= 4) ? 64'h3333 : 64'h1111);
    end
    check_val("b2b_result", 64'(cx.result_o), 64'h33333333);
    cx.en_i = 1'b0;
    tick();

    // Maximum fixed delay
    run_fixed(15, 1, 32'h0F0F_0F0F, 32'hF0F0_F0F0);

    // Asynchronous reset in the middle of BUSY
    cx.en_i = 1'b1; cx.operator_i = 2'd2; cx.delay_i = 4'd5;
    cx.operand_a_i = 32'h7777_7777; cx.operand_b_i = 32'h8888_8888;
    tick(); tick();
    check_val("arst_pre_busy", {63'b0, cx.busy_o}, 64'd1);
    #2 rst = 1'b1;
    #1;
    check_val("arst_busy", {63'b0, cx.busy_o}, 64'd0);
    check_val("arst_ready", {63'b0, cx.ready_o}, 64'd0);
    check_val("arst_result", 64'(cx.result_o), 64'd0);
    check_val("arst_opa", 64'(cx.efpga_operand_a_o), 64'd0);
    check_val("arst_opb", 64'(cx.efpga_operand_b_o), 64'd0);
    check_val("arst_start", {63'b0, cx.efpga_start_o}, 64'd0);
    cx.en_i = 1'b0;
    #1 rst = 1'b0;
    tick();
    check_val("arst_idle_busy", {63'b0, cx.busy_o}, 64'd0);

`ifdef EFPGA_CX_TIMEOUT_EN
    // Handshake timeout with TIMEOUT=10, done never raised
    cx.en_i = 1'b1; cx.operator_i = 2'd2; cx.delay_i = 4'd0;
    for (int c = 1; c <= 11; c++) begin
      tick();
      check_val($sformatf("to_c%0d_ready", c), {63'b0, cx.ready_o}, {63'b0, c == 11});
      check_val($sformatf("to_c%0d_err", c), {63'b0, cx.err_o}, {63'b0, c == 11});
    end
    check_val("to_result", 64'(cx.result_o), 64'd0);
    cx.en_i = 1'b0;
    tick();
    check_val("to_err_held", {63'b0, cx.err_o}, 64'd1);
    run_fixed(1, 3, 32'h1, 32'h2);
`endif

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/ibex_efpga_cx_unit.md
Name: ibex_efpga_cx_unit

Overview:
Multi-cycle custom-instruction (CX) execution unit for the eFPGA fabric. It is instantiated in the EX stage beside ALU and multdiv and drives the eFPGA leg of ex_ready / regfile write data. Compared with the previous single-result, fixed-delay eFPGA hook, it generalises to NUM_CH result channels and supports two completion modes per operation: fixed latency and done-handshake. It registers operands toward the fabric and holds the captured result until the EX stage accepts it.

Parameters:
NUM_CH, 4, number of eFPGA result channels; power of 2, minimum 2
DATA_W, 32, operand/result width
DELAY_W, 4, width of the per-op delay field
TIMEOUT, 255, handshake-mode cycle limit (only with EFPGA_CX_TIMEOUT_EN)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
en_i  in  1  CX instruction present in EX; held high until ready_o
operator_i  in  $clog2(NUM_CH)  result channel select (cx_optype)
operand_a_i  in  DATA_W  rs1 value
operand_b_i  in  DATA_W  rs2 value
delay_i  in  DELAY_W  0 = handshake mode; N>0 = fixed latency of N cycles
kill_i  in  1  flush/abort from controller
efpga_operand_a_o  out  DATA_W  registered operand A to fabric
efpga_operand_b_o  out  DATA_W  registered operand B to fabric
efpga_start_o  out  1  one-cycle start pulse to fabric
efpga_result_i  in  NUM_CH*DATA_W  packed fabric results; channel k = bits [k*DATA_W +: DATA_W]
efpga_done_i  in  NUM_CH  per-channel completion (handshake mode only)
result_o  out  DATA_W  captured result, valid while ready_o=1
ready_o  out  1  operation complete; EX may advance
busy_o  out  1  unit in BUSY state
err_o  out  1  timeout flag (constant 0 when feature is off)

Behaviour:
- Reset (async, rst=1): state=IDLE, all outputs 0, operand/result/counter registers 0.
- FSM states: IDLE, BUSY, DONE.
- IDLE, en_i=1, kill_i=0: latch operand_a_i/b_i into the efpga_operand registers. Latch operator_i to ch_q and delay_i to cnt_q. Set mode_q = (delay_i==0). Next state is BUSY. efpga_start_o=1 in the first BUSY cycle only. ready_o=0 in IDLE.
- BUSY, fixed mode: cnt_q decrements each cycle. When cnt_q==1, capture efpga_result_i[ch_q] into result_q and go to DONE. BUSY lasts exactly delay_i cycles.
- BUSY, handshake mode: stay in BUSY until efpga_done_i[ch_q]=1. On that edge, capture efpga_result_i[ch_q] and go to DONE. Done bits of other channels are ignored. If done is already high in the first BUSY cycle, the result is captured in that cycle.
- DONE: ready_o=1 and result_o=result_q for exactly one cycle, then IDLE. en_i in DONE is ignored; a back-to-back op is accepted from IDLE on the following cycle.
- Latency: the accept edge is cycle 0. ready_o is high in cycle D+1 for fixed delay D. In handshake mode it is high in the cycle after done is sampled.
- result_o holds its last captured value outside DONE. It is updated only on capture.
- kill_i=1 in any state: next state is IDLE and no capture occurs. ready_o is forced 0 in that cycle and efpga_start_o is suppressed. kill_i has priority over en_i, over done, and over counter expiry.
- Operand outputs remain stable from accept until the unit returns to IDLE.
- busy_o = (state==BUSY).
- Deasserting en_i while BUSY is a protocol error; the unit ignores it and completes the operation.

Optional Feature:
EFPGA_CX_TIMEOUT_EN
- Defined: in handshake mode a counter tracks BUSY cycles. If TIMEOUT cycles elapse without efpga_done_i[ch_q], the unit goes to DONE with result_q=0 and err_o=1 for that DONE cycle. err_o is cleared on the next accept or on kill. Fixed mode is unaffected.
- Undefined: no timeout counter exists; handshake mode waits indefinitely and err_o is tied 0.

Test Plan:
- Fixed mode: delay_i=3, operator_i=2, channel 2 = 0xDEADBEEF. Expected: start pulse in cycle 1; ready_o=1 only in cycle 4; result_o=0xDEADBEEF; busy_o high in cycles 1-3.
- Handshake mode: delay_i=0, operator_i=1. Raise done[0] in cycle 2, then done[1] in cycle 5 with ch1=0x12345678. Expected: done[0] ignored; ready_o=1 in cycle 6; result_o=0x12345678.
- Kill mid-op: delay_i=8, kill_i=1 in cycle 4. Expected: IDLE in cycle 5; ready_o never asserted; result_o keeps its previous value. A new op issued in cycle 5 completes normally.
- Back-to-back: two delay_i=1 ops with en_i held. Expected: ready_o in cycles 2 and 5; second start pulse in cycle 4; operand outputs switch at the second accept.
- Boundaries: delay_i=15 (max), expect ready_o in cycle 16. rst asserted asynchronously mid-BUSY, expect all outputs 0 immediately and the FSM in IDLE.
- With EFPGA_CX_TIMEOUT_EN and TIMEOUT=10: delay_i=0, done never raised. Expected: ready_o=1, err_o=1, result_o=0 in cycle 11; err_o cleared on the next accept.
